// File: rtl/instr_mem_if.sv
// Request/valid fetch bus and byte-enabled program-load port for instr_mem_fetch.
// The master drives writes and requests; the slave (the memory) returns words.
interface instr_mem_if #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned WORD_BYTES = 4
);
    logic                      we_i;
    logic [ADDR_W-1:0]         waddr_i;
    logic [8*WORD_BYTES-1:0]   wd_i;
    logic [WORD_BYTES-1:0]     wbe_i;
    logic                      req_i;
    logic [ADDR_W-1:0]         raddr_i;
    logic                      busy_o;
    logic                      valid_o;
    logic [8*WORD_BYTES-1:0]   instr_o;
    logic                      err_o;

    modport master (
        output we_i, waddr_i, wd_i, wbe_i, req_i, raddr_i,
        input  busy_o, valid_o, instr_o, err_o
    );

    modport slave (
        input  we_i, waddr_i, wd_i, wbe_i, req_i, raddr_i,
        output busy_o, valid_o, instr_o, err_o
    );
endinterface

// File: rtl/instr_mem_fetch.sv
// Byte-addressed instruction memory with a one-byte-per-cycle word fetch engine.
// Define INSTR_MEM_ALIGN_CHK_EN to reject misaligned fetch requests with an err_o pulse.
module instr_mem_fetch #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_BYTES),
    parameter int unsigned WORD_BYTES  = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    instr_mem_if.slave bus
);
    localparam int unsigned CNT_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int unsigned WORD_W = 8 * WORD_BYTES;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [7:0]        mem_q [DEPTH_BYTES];

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic              valid_q, valid_d;
    logic              err_q,   err_d;

    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_byte;
    logic              last_byte;
    logic              misalign;

    // Storage is deliberately not reset; address sums wrap at DEPTH_BYTES by width.
    always_ff @(posedge clk_i) begin
        if (bus.we_i) begin
            for (int k = 0; k < WORD_BYTES; k++) begin
                if (bus.wbe_i[k]) begin
                    mem_q[bus.waddr_i + ADDR_W'(k)] <= bus.wd_i[8*k +: 8];
                end
            end
        end
    end

    assign rd_addr   = base_q + ADDR_W'(cnt_q);
    assign rd_byte   = mem_q[rd_addr];
    assign last_byte = (cnt_q == CNT_W'(WORD_BYTES - 1));

`ifdef INSTR_MEM_ALIGN_CHK_EN
    assign misalign = ((32'(bus.raddr_i) % 32'(WORD_BYTES)) != 32'd0);
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_i) begin
                    if (misalign) begin
                        err_d = 1'b1;
                    end else begin
                        base_d  = bus.raddr_i;
                        cnt_d   = '0;
                        instr_d = '0;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                // A write on this edge takes the cycle; the byte is read once it lands.
                if (!bus.we_i) begin
                    instr_d[{cnt_q, 3'b000} +: 8] = rd_byte;
                    if (last_byte) begin
                        valid_d = 1'b1;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy_o  = (state_q != ST_IDLE);
    assign bus.valid_o = valid_q;
    assign bus.instr_o = instr_q;
    assign bus.err_o   = err_q;

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Scoreboard bench for instr_mem_fetch: expected words queued at accept, checked on valid_o.
module tb_instr_mem_fetch;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    instr_mem_if #(.ADDR_W(8), .WORD_BYTES(4)) ifc ();

    instr_mem_fetch #(
        .DEPTH_BYTES(256),
        .ADDR_W     (8),
        .WORD_BYTES (4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (ifc)
    );

    always #5 clk_i = ~clk_i;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_q [$];
    logic [7:0]  mem_m [256];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [7:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mem_m[a + 8'(k)];
        return w;
    endfunction

    always @(negedge clk_i) begin
        if (ifc.valid_o || ifc.err_o) check("vld_err_excl", 32'(ifc.valid_o & ifc.err_o), 32'd0);
        if (ifc.valid_o) begin
            if (exp_q.size() == 0) check("unexp_valid", 32'd1, 32'd0);
            else                   check("instr", ifc.instr_o, exp_q.pop_front());
        end
    end

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk_i); #1;
        ifc.we_i = 1'b1; ifc.waddr_i = a; ifc.wd_i = d; ifc.wbe_i = be;
        @(posedge clk_i); #1;
        ifc.we_i = 1'b0;
        for (int k = 0; k < 4; k++) if (be[k]) mem_m[a + 8'(k)] = d[8*k +: 8];
    endtask

    // stall_cyc > 0 writes byte sd to sa on edge accept+stall_cyc.
    task automatic fetch(input logic [7:0] a, input int stall_cyc, input logic [7:0] sa,
                         input logic [7:0] sd, input int exp_lat);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        @(posedge clk_i); #1;
        ifc.req_i = 1'b1; ifc.raddr_i = a;
        @(posedge clk_i); #1;
        ifc.req_i = 1'b0;
        check("clr_on_accept", ifc.instr_o, 32'd0);
        check("busy_accept", 32'(ifc.busy_o), 32'd1);
        if (stall_cyc > 0) mem_m[sa] = sd;
        exp_q.push_back(word_at(a));
        while (!got && lat < 20) begin
            if (lat + 1 == stall_cyc) begin
                ifc.we_i = 1'b1; ifc.waddr_i = sa; ifc.wd_i = {24'h0, sd}; ifc.wbe_i = 4'h1;
            end
            @(posedge clk_i); #1;
            ifc.we_i = 1'b0;
            lat++;
            if (ifc.valid_o) got = 1'b1;
            else if (lat == exp_lat - 1) check("busy_hold", 32'(ifc.busy_o), 32'd1);
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("busy_done", 32'(ifc.busy_o), 32'd0);
        check("err_quiet", 32'(ifc.err_o), 32'd0);
    endtask

    initial begin
        int n_v;
        int t0;
        int t1;
        ifc.we_i = 1'b0; ifc.waddr_i = '0; ifc.wd_i = '0; ifc.wbe_i = '0;
        ifc.req_i = 1'b0; ifc.raddr_i = '0;
        #1;
        check("rst_busy",  32'(ifc.busy_o),  32'd0);
        check("rst_valid", 32'(ifc.valid_o), 32'd0);
        check("rst_err",   32'(ifc.err_o),   32'd0);
        check("rst_instr", ifc.instr_o,      32'd0);
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b0;

        // Basic load and fetch
        wr(8'h10, 32'h00852020, 4'hF);
        fetch(8'h10, 0, 8'h00, 8'h00, 4);
        check("t1_word", ifc.instr_o, 32'h00852020);

        // Partial byte enables over older data
        wr(8'h20, 32'h11223344, 4'hF);
        wr(8'h20, 32'hAABBCCDD, 4'b0101);
        fetch(8'h20, 0, 8'h00, 8'h00, 4);
        check("t2_word", ifc.instr_o, 32'h11BB33DD);

        // Write stall during fetch cycle 2, patching the top byte
        fetch(8'h10, 2, 8'h13, 8'hEE, 5);
        check("t3_byte3", 32'(ifc.instr_o[31:24]), 32'h000000EE);
        repeat (3) @(posedge clk_i);
        check("t3_hold", ifc.instr_o, 32'hEE852020);

        // Asynchronous reset mid-fetch
        @(posedge clk_i); #1;
        ifc.req_i = 1'b1; ifc.raddr_i = 8'h20;
        @(posedge clk_i); #1;
        ifc.req_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b1;
        #1;
        check("t4_busy",  32'(ifc.busy_o),  32'd0);
        check("t4_valid", 32'(ifc.valid_o), 32'd0);
        check("t4_instr", ifc.instr_o,      32'd0);
        #2 rst_i = 1'b0;
        repeat (6) @(posedge clk_i);
        fetch(8'h20, 0, 8'h00, 8'h00, 4);

        // req_i held high; mid-fetch address changes must be ignored
        wr(8'h00, 32'h04030201, 4'hF);
        wr(8'h04, 32'h08070605, 4'hF);
        @(posedge clk_i); #1;
        ifc.req_i = 1'b1; ifc.raddr_i = 8'h00;
        exp_q.push_back(word_at(8'h00));
        exp_q.push_back(word_at(8'h04));
        @(posedge clk_i); #1;
        ifc.raddr_i = 8'h10;
        n_v = 0; t0 = 0; t1 = 0;
        for (int c = 1; c <= 12; c++) begin
            if (c == 3) ifc.raddr_i = 8'h04;
            @(posedge clk_i); #1;
            if (c == 5) ifc.req_i = 1'b0;
            if (ifc.valid_o) begin
                if (n_v == 0) t0 = c; else t1 = c;
                n_v++;
            end
        end
        check("t5_count", 32'(n_v), 32'd2);
        check("t5_first", 32'(t0), 32'd4);
        check("t5_second", 32'(t1), 32'd9);

        // Misaligned request straddling the top of memory
        wr(8'hFC, 32'hDDCCBBAA, 4'hF);
`ifdef INSTR_MEM_ALIGN_CHK_EN
        @(posedge clk_i); #1;
        ifc.req_i = 1'b1; ifc.raddr_i = 8'hFE;
        @(posedge clk_i); #1;
        ifc.req_i = 1'b0;
        check("t6_err",   32'(ifc.err_o),  32'd1);
        check("t6_busy",  32'(ifc.busy_o), 32'd0);
        @(posedge clk_i); #1;
        check("t6_err_pulse", 32'(ifc.err_o),  32'd0);
        check("t6_busy_idle", 32'(ifc.busy_o), 32'd0);
`else
        fetch(8'hFE, 0, 8'h00, 8'h00, 4);
        check("t6_wrap", ifc.instr_o, 32'h0201DDCC);
`endif

        repeat (4) @(posedge clk_i);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end
endmodule
